slib_baud_gen: RTL and testbench

- Runtime-programmable clock-enable divider for the UART datapath.
- Divides CE pulses by a software-written divisor to produce an oversampling tick (BAUDX) and, from that, a 1x bit-rate tick (BAUD) plus the oversample phase.
- Generalises the fixed-ratio clock divider with four additions:
  - a programmable divisor width;
  - glitch-free divisor updates on period boundaries;
  - a synchronous restart;
  - a second cascaded stage.

---
 rtl/slib_baud_gen.sv | 148 ++++++++++++++
 tb/tb_slib_baud_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slib_baud_gen.sv
// slib_baud_gen -- runtime-programmable two-stage clock-enable divider.
//
// Stage 1 divides CE pulses by a software-written divisor to produce the
// oversampling tick BAUDX. Stage 2 counts BAUDX ticks modulo OVERSAMPLE to
// produce the bit-rate tick BAUD and the current oversample phase.
//
// Divisor writes land in a shadow register and are applied on a stage-1
// period boundary, so a running period is never truncated or stretched.
// From idle (applied divisor 0) a write applies at once. A write on the
// terminal-count cycle bypasses the shadow and takes effect for the next
// period.
//
// Ports:
//   CLK     system clock, rising edge
//   RSTN    asynchronous active-low reset
//   CE      count enable for stage 1
//   CLR     synchronous restart of both stages (wins over CE)
//   DIV     new divisor value
//   DIV_WE  write strobe for DIV
//   BAUDX   one-cycle oversample tick (registered)
//   BAUD    one-cycle bit-rate tick (registered, coincides with BAUDX)
//   PHASE   stage-2 count, 0..OVERSAMPLE-1
//   ACTIVE  applied divisor is non-zero (registered)
module slib_baud_gen #(
  parameter int WIDTH      = 16,
  parameter int OVERSAMPLE = 16,
  localparam int PW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIV,
  input  logic             DIV_WE,
  output logic             BAUDX,
  output logic             BAUD,
  output logic [PW-1:0]    PHASE,
  output logic             ACTIVE
);

  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  // Divisor register path
  logic [WIDTH-1:0] div_act, div_sh;
  logic             pending;
  logic [WIDTH-1:0] div_act_nxt, div_sh_nxt;
  logic             pending_nxt;

  // Counters and ticks
  logic [WIDTH-1:0] cnt1, cnt1_nxt;
  logic [PW-1:0]    cnt2, cnt2_nxt;
  logic             baudx_nxt, baud_nxt;

  logic idle, tc;

  // div_act >= 1 whenever tc can be true, so div_act-1 cannot wrap.
  assign idle = (div_act == '0);
  assign tc   = CE & ~idle & (cnt1 == (div_act - WIDTH'(1)));

  // ---------------------------------------------------------------------
  // Divisor update
  // ---------------------------------------------------------------------
  always_comb begin
    div_sh_nxt  = DIV_WE ? DIV : div_sh;
    div_act_nxt = div_act;
    pending_nxt = pending;
    if (CLR) begin
      // A restart is itself a period boundary: apply whatever is newest.
      if (DIV_WE) begin
        div_act_nxt = DIV;
        pending_nxt = 1'b0;
      end else if (pending) begin
        div_act_nxt = div_sh;
        pending_nxt = 1'b0;
      end
    end else if (DIV_WE) begin
      // Idle or at a boundary right now: take DIV directly, skip the shadow.
      if (idle || tc) begin
        div_act_nxt = DIV;
        pending_nxt = 1'b0;
      end else begin
        pending_nxt = 1'b1;
      end
    end else if (tc && pending) begin
      div_act_nxt = div_sh;
      pending_nxt = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 / stage 2 counters
  // ---------------------------------------------------------------------
  always_comb begin
    cnt1_nxt  = cnt1;
    cnt2_nxt  = cnt2;
    baudx_nxt = 1'b0;
    baud_nxt  = 1'b0;
    if (CLR) begin
      cnt1_nxt = '0;
      cnt2_nxt = '0;
    end else if (DIV_WE && idle) begin
      // New period starts from a clean count when leaving idle.
      cnt1_nxt = '0;
    end else if (CE && !idle) begin
      if (tc) begin
        cnt1_nxt  = '0;
        baudx_nxt = 1'b1;
        if (cnt2 == PH_LAST) begin
          cnt2_nxt = '0;
          baud_nxt = 1'b1;
        end else begin
          cnt2_nxt = cnt2 + 1'b1;
        end
      end else begin
        cnt1_nxt = cnt1 + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      div_act <= '0;
      div_sh  <= '0;
      pending <= 1'b0;
      cnt1    <= '0;
      cnt2    <= '0;
      BAUDX   <= 1'b0;
      BAUD    <= 1'b0;
      ACTIVE  <= 1'b0;
    end else begin
      div_act <= div_act_nxt;
      div_sh  <= div_sh_nxt;
      pending <= pending_nxt;
      cnt1    <= cnt1_nxt;
      cnt2    <= cnt2_nxt;
      BAUDX   <= baudx_nxt;
      BAUD    <= baud_nxt;
      // Registered alongside div_act so it changes on the same edge.
      ACTIVE  <= (div_act_nxt != '0);
    end
  end

  assign PHASE = cnt2;

endmodule

// File: tb/tb_slib_baud_gen.sv
module tb_slib_baud_gen;
  localparam int W  = 16;
  localparam int OS = 16;
  localparam int PW = 4;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          CE = 1'b0, CLR = 1'b0, DIV_WE = 1'b0;
  logic [W-1:0]  DIV = '0;
  logic          BAUDX, BAUD, ACTIVE;
  logic [PW-1:0] PHASE;

  int chk  = 0;
  int pass = 0;

  always #5 CLK = ~CLK;

  slib_baud_gen #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .CLR(CLR), .DIV(DIV), .DIV_WE(DIV_WE),
    .BAUDX(BAUDX), .BAUD(BAUD), .PHASE(PHASE), .ACTIVE(ACTIVE)
  );

  wire [PW+2:0] dut_outs = {BAUDX, BAUD, PHASE, ACTIVE};

  // Reference model: period = number of CE cycles, ticks counted since the
  // last restart; phase and BAUD follow from the tick count by arithmetic.
  int m_act, m_sh, m_ce_seen, m_ticks;
  bit m_pend, e_x, e_b;

  task automatic m_reset();
    m_act = 0; m_sh = 0; m_ce_seen = 0; m_ticks = 0; m_pend = 0;
    e_x = 0; e_b = 0;
  endtask

  task automatic m_clock(input bit ce, input bit clr, input bit we, input int d);
    bit tick;
    e_x = 0; e_b = 0;
    if (clr) begin
      m_ticks = 0; m_ce_seen = 0;
      if (we) begin m_sh = d; m_act = d; m_pend = 0; end
      else if (m_pend) begin m_act = m_sh; m_pend = 0; end
    end else begin
      tick = ce && (m_act != 0) && (m_ce_seen + 1 == m_act);
      if (ce && m_act != 0) m_ce_seen = tick ? 0 : m_ce_seen + 1;
      if (tick) begin
        m_ticks++;
        e_x = 1;
        e_b = (m_ticks % OS == 0);
      end
      if (we) begin
        m_sh = d;
        if (m_act == 0 || tick) begin m_act = d; m_pend = 0; m_ce_seen = 0; end
        else m_pend = 1;
      end else if (tick && m_pend) begin
        m_act = m_sh; m_pend = 0;
      end
    end
  endtask

  function automatic logic [PW+2:0] m_outs();
    return {e_x, e_b, PW'(m_ticks % OS), (m_act != 0)};
  endfunction

  task automatic step(input bit ce, input bit clr, input bit we, input int d);
    CE = ce; CLR = clr; DIV_WE = we; DIV = W'(d);
    @(posedge CLK);
    m_clock(ce, clr, we, d);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; CE = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk++;
    if (dut_outs !== '0) $display("FAIL reset_hold got %b want 0", dut_outs); else pass++;
    @(negedge CLK); RSTN = 1'b1; m_reset();
    for (int i = 0; i < 50; i++) begin
      step(1, 0, 0, 0);
      chk++;
      if (dut_outs !== m_outs() || dut_outs !== '0)
        $display("FAIL reset_idle cyc %0d got %b want %b", i, dut_outs, m_outs());
      else pass++;
    end
  endtask

  task automatic test_basic();
    int last_x, last_b;
    step(1, 0, 1, 3);
    chk++;
    if (ACTIVE !== 1'b1) $display("FAIL basic_active got %b want 1", ACTIVE); else pass++;
    last_x = 0; last_b = 0;
    for (int i = 1; i <= 150; i++) begin
      step(1, 0, 0, 0);
      chk++;
      if (dut_outs !== m_outs()) $display("FAIL basic cyc %0d got %b want %b", i, dut_outs, m_outs());
      else pass++;
      if (BAUDX) begin
        chk++;
        if (i - last_x != 3) $display("FAIL basic_xgap got %0d want 3", i - last_x); else pass++;
        last_x = i;
      end
      if (BAUD) begin
        chk++;
        if (i - last_b != 48 || PHASE !== 0)
          $display("FAIL basic_bgap got gap %0d ph %0d want gap 48 ph 0", i - last_b, PHASE);
        else pass++;
        last_b = i;
      end
    end
  endtask

  task automatic test_gated_ce();
    int last_x;
    step(0, 1, 1, 2);
    last_x = -1;
    for (int i = 1; i <= 40; i++) begin
      step(i % 2 == 1, 0, 0, 0);
      chk++;
      if (dut_outs !== m_outs()) $display("FAIL gated cyc %0d got %b want %b", i, dut_outs, m_outs());
      else pass++;
      if (BAUDX) begin
        chk++;
        if (i - last_x != 4) $display("FAIL gated_gap got %0d want 4", i - last_x); else pass++;
        last_x = i;
      end
    end
  endtask

  task automatic test_update();
    bit we, want_x;
    int d;
    step(0, 1, 1, 5);
    for (int i = 1; i <= 24; i++) begin
      we = (i == 2) || (i == 13);
      d  = (i == 2) ? 2 : 4;
      step(1, 0, we, d);
      want_x = (i == 5) || (i == 7) || (i == 9) || (i == 11) || (i == 13) ||
               (i == 17) || (i == 21);
      chk++;
      if (BAUDX !== want_x || dut_outs !== m_outs())
        $display("FAIL update cyc %0d got %b want %b (x %b)", i, dut_outs, m_outs(), want_x);
      else pass++;
    end
  endtask

  task automatic test_extremes();
    bit ce;
    int n;
    // DIV=1: tick for every CE cycle
    step(0, 1, 1, 1);
    for (int i = 0; i < 30; i++) begin
      ce = $urandom_range(0, 1);
      step(ce, 0, 0, 0);
      chk++;
      if (BAUDX !== ce || dut_outs !== m_outs())
        $display("FAIL div1 cyc %0d got %b want %b", i, dut_outs, m_outs());
      else pass++;
    end
    // Maximum divisor
    step(0, 1, 1, 65535);
    n = 0;
    while (n < 70000) begin
      step(1, 0, 0, 0);
      n++;
      if (BAUDX) break;
    end
    chk++;
    if (n != 65535) $display("FAIL divmax_period got %0d want 65535", n); else pass++;
    chk++;
    if (dut_outs !== m_outs()) $display("FAIL divmax_outs got %b want %b", dut_outs, m_outs());
    else pass++;
    // Writing 0: last period completes, ACTIVE drops on that boundary
    step(0, 1, 1, 3);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    chk++;
    if (ACTIVE !== 1'b1 || BAUDX !== 1'b0)
      $display("FAIL div0_pending got x%b a%b want x0 a1", BAUDX, ACTIVE);
    else pass++;
    step(1, 0, 0, 0);
    chk++;
    if (BAUDX !== 1'b1 || ACTIVE !== 1'b0)
      $display("FAIL div0_boundary got x%b a%b want x1 a0", BAUDX, ACTIVE);
    else pass++;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      chk++;
      if (BAUDX !== 1'b0 || ACTIVE !== 1'b0 || dut_outs !== m_outs())
        $display("FAIL div0_stopped cyc %0d got %b want %b", i, dut_outs, m_outs());
      else pass++;
    end
  endtask

  task automatic test_clr();
    int n;
    step(0, 1, 1, 3);
    n = 0;
    while (!(m_ticks % OS == 7 && m_ce_seen == 2) && n < 200) begin
      step(1, 0, 0, 0);
      n++;
    end
    chk++;
    if (n >= 200 || PHASE !== 4'd7) $display("FAIL clr_setup got ph %0d want 7", PHASE);
    else pass++;
    step(1, 1, 0, 0);
    chk++;
    if (BAUDX !== 1'b0 || PHASE !== 4'd0 || dut_outs !== m_outs())
      $display("FAIL clr_tc got %b want %b", dut_outs, m_outs());
    else pass++;
    n = 0;
    while (n < 20) begin
      step(1, 0, 0, 0);
      n++;
      if (BAUDX) break;
    end
    chk++;
    if (n != 3) $display("FAIL clr_next got %0d want 3", n); else pass++;
  endtask

  task automatic test_async_reset();
    step(0, 1, 1, 3);
    repeat (4) step(1, 0, 0, 0);
    chk++;
    if (ACTIVE !== 1'b1) $display("FAIL arst_pre got a%b want 1", ACTIVE); else pass++;
    #2 RSTN = 1'b0;
    #1;
    chk++;
    if (dut_outs !== '0) $display("FAIL arst_async got %b want 0", dut_outs); else pass++;
    m_reset();
    @(posedge CLK); #1;
    chk++;
    if (dut_outs !== '0) $display("FAIL arst_hold got %b want 0", dut_outs); else pass++;
    @(negedge CLK); RSTN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0);
      chk++;
      if (dut_outs !== m_outs() || dut_outs !== '0)
        $display("FAIL arst_after cyc %0d got %b want %b", i, dut_outs, m_outs());
      else pass++;
    end
  endtask

  task automatic test_random();
    bit ce, clr, we;
    int d;
    step(0, 1, 1, 3);
    for (int i = 0; i < 3000; i++) begin
      ce  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 29) == 0);
      d   = $urandom_range(0, 7);
      step(ce, clr, we, d);
      chk++;
      if (dut_outs !== m_outs())
        $display("FAIL random cyc %0d got %b want %b", i, dut_outs, m_outs());
      else pass++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_gated_ce();
    test_update();
    test_extremes();
    test_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
